// File: rtl/alu_cmd_driver_pkg.sv
// Shared types and constants for the tinyalu command driver and its scoreboard.
package alu_drv_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    // Done latency of the ALU after it samples alu_start, in cycles.
    localparam int MUL_LATENCY    = 4;
    localparam int SINGLE_LATENCY = 1;

    typedef enum logic [OP_W-1:0] {
        NOP = 3'b000,
        ADD = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        MUL = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command/response bundle between a stimulus sequencer (master) and the driver (slave).
interface alu_cmd_driver_if;

    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [alu_drv_pkg::OP_W-1:0]   cmd_op;
    logic [alu_drv_pkg::DATA_W-1:0] cmd_a;
    logic [alu_drv_pkg::DATA_W-1:0] cmd_b;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [alu_drv_pkg::RES_W-1:0]  rsp_result;
    logic [alu_drv_pkg::OP_W-1:0]   rsp_op;
    logic                           rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_cmd_driver.sv
// Single-outstanding initiator for the tinyalu start/done protocol with a
// done-timeout guard; every output is registered.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_cmd_driver_if.slave   cmd_if,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    drv_state_e state;
    logic [7:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            to_cnt            <= '0;
            cmd_if.cmd_ready  <= 1'b0;
            alu_start         <= 1'b0;
            alu_op            <= '0;
            alu_a             <= '0;
            alu_b             <= '0;
            cmd_if.rsp_valid  <= 1'b0;
            cmd_if.rsp_result <= '0;
            cmd_if.rsp_op     <= '0;
            cmd_if.rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                        cmd_if.cmd_ready <= 1'b0;
                        if (cmd_if.cmd_op == NOP) begin
                            // NOP answers locally; the ALU never sees a start pulse.
                            cmd_if.rsp_result <= '0;
                            cmd_if.rsp_op     <= NOP;
                            cmd_if.rsp_err    <= 1'b0;
                            cmd_if.rsp_valid  <= 1'b1;
                            state             <= RESP;
                        end else begin
                            alu_op    <= cmd_if.cmd_op;
                            alu_a     <= cmd_if.cmd_a;
                            alu_b     <= cmd_if.cmd_b;
                            alu_start <= 1'b1;
                            to_cnt    <= '0;
                            state     <= ISSUE;
                        end
                    end else begin
                        cmd_if.cmd_ready <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (alu_done) begin
                        cmd_if.rsp_result <= alu_result;
                        cmd_if.rsp_op     <= alu_op;
                        cmd_if.rsp_err    <= 1'b0;
                        cmd_if.rsp_valid  <= 1'b1;
                        alu_start         <= 1'b0;
                        state             <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        cmd_if.rsp_result <= '0;
                        cmd_if.rsp_op     <= alu_op;
                        cmd_if.rsp_err    <= 1'b1;
                        cmd_if.rsp_valid  <= 1'b1;
                        alu_start         <= 1'b0;
                        state             <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                RESP: begin
                    // Leaving RESP through IDLE keeps alu_start low between commands.
                    if (cmd_if.rsp_ready) begin
                        cmd_if.rsp_valid <= 1'b0;
                        cmd_if.cmd_ready <= 1'b1;
                        state            <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench: table vectors, random commands against a reference
// model, and hand-written timeout/reset/throughput sequences.
module tb_alu_cmd_driver;
    import alu_drv_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result;

    alu_cmd_driver_if bus ();

    alu_cmd_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_if     (bus.slave),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU behaviour: 8-bit ops zero-extended, MUL is the full product.
    function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        if (op[2]) return 16'(a) * 16'(b);
        case (op[1:0])
            2'b01:   begin s = a + b; return {8'h00, s}; end
            2'b10:   return {8'h00, a & b};
            2'b11:   return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op);
        if (op == 3'b000) return 0;
        return (op[2] ? MUL_LATENCY : SINGLE_LATENCY) + 1;
    endfunction

    // Behavioural tinyalu: starts on a rising alu_start, answers after its latency.
    logic        alu_en = 1'b1;
    logic        spur_done = 1'b0;
    logic        model_done = 1'b0;
    logic [15:0] model_res = '0;
    logic        prev_start = 1'b0;
    logic        busy = 1'b0;
    int          lat_cnt = 0;
    int          start_rises = 0;
    int          cyc = 0;

    assign alu_done   = model_done | spur_done;
    assign alu_result = model_done ? model_res : 16'hDEAD;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= alu_start;
        model_done <= 1'b0;
        if (alu_start && !prev_start) start_rises <= start_rises + 1;
        if (!reset_n) begin
            busy    <= 1'b0;
            lat_cnt <= 0;
        end else if (alu_start && !prev_start && !busy && alu_en) begin
            model_res <= ref_result(alu_op, alu_a, alu_b);
            if (alu_op[2]) begin
                busy    <= 1'b1;
                lat_cnt <= MUL_LATENCY - 1;
            end else begin
                model_done <= 1'b1;
            end
        end else if (busy) begin
            if (lat_cnt == 1) begin
                model_done <= 1'b1;
                busy       <= 1'b0;
            end
            lat_cnt <= lat_cnt - 1;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic        en;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic run_cmd(input vec_t v, input string tag, output int acc_cyc);
        int w, n, rises0;
        logic held_ok, stable_ok;
        logic [15:0] r;
        logic [2:0] o;
        logic e;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " accept_ready"}, 32'(bus.cmd_ready), 32'd1);
        alu_en        = v.en;
        bus.rsp_ready = (v.hold == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        rises0        = start_rises;
        @(posedge clk);
        @(negedge clk);
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = ~v.a;
        bus.cmd_b     = ~v.b;
        n = 0;
        held_ok = 1'b1;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            if (alu_op !== v.op || alu_a !== v.a || alu_b !== v.b) held_ok = 1'b0;
            if (bus.cmd_ready !== 1'b0) held_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(v.exp_lat));
        if (v.op != 3'b000) check({tag, " operands_held"}, 32'(held_ok), 32'd1);
        r = bus.rsp_result;
        o = bus.rsp_op;
        e = bus.rsp_err;
        check({tag, " result"}, 32'(r), 32'(v.exp_res));
        check({tag, " err"}, 32'(e), 32'(v.exp_err));
        if (!v.exp_err) check({tag, " op"}, 32'(o), 32'(v.op));
        if (v.hold > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== r || bus.rsp_op !== o ||
                    bus.rsp_err !== e || bus.cmd_ready !== 1'b0) stable_ok = 1'b0;
            end
            check({tag, " rsp_stable"}, 32'(stable_ok), 32'd1);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " rsp_valid_after_hs"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " cmd_ready_after_hs"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, " start_pulses"}, 32'(start_rises - rises0), (v.op == 3'b000) ? 32'd0 : 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        int   c0, c1, c2;
        logic quiet;

        tbl[0] = '{op: 3'b001, a: 8'h10, b: 8'h20, hold: 0, en: 1'b1, exp_res: 16'h0030, exp_err: 1'b0, exp_lat: 2};
        tbl[1] = '{op: 3'b100, a: 8'hFF, b: 8'hFF, hold: 0, en: 1'b1, exp_res: 16'hFE01, exp_err: 1'b0, exp_lat: 5};
        tbl[2] = '{op: 3'b000, a: 8'h12, b: 8'h34, hold: 0, en: 1'b1, exp_res: 16'h0000, exp_err: 1'b0, exp_lat: 0};
        tbl[3] = '{op: 3'b011, a: 8'hF0, b: 8'h3C, hold: 3, en: 1'b1, exp_res: 16'h00CC, exp_err: 1'b0, exp_lat: 2};
        tbl[4] = '{op: 3'b010, a: 8'hF0, b: 8'h3C, hold: 0, en: 1'b1, exp_res: 16'h0030, exp_err: 1'b0, exp_lat: 2};
        tbl[5] = '{op: 3'b111, a: 8'h12, b: 8'h10, hold: 1, en: 1'b1, exp_res: 16'h0120, exp_err: 1'b0, exp_lat: 5};
        tbl[6] = '{op: 3'b001, a: 8'hFF, b: 8'h02, hold: 0, en: 1'b1, exp_res: 16'h0001, exp_err: 1'b0, exp_lat: 2};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset alu_start", 32'(alu_start), 32'd0);
        check("reset alu_ops", 32'({alu_op, alu_a, alu_b}), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_fields", 32'({bus.rsp_result, bus.rsp_op, bus.rsp_err}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready after release", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_cmd(tbl[i], $sformatf("vec%0d", i), c0);

        // Missing done: abort after TIMEOUT_CYCLES, then a late done in IDLE must be ignored.
        v = '{op: 3'b001, a: 8'h05, b: 8'h06, hold: 0, en: 1'b0, exp_res: 16'h0000, exp_err: 1'b1, exp_lat: TO};
        run_cmd(v, "timeout", c0);
        alu_en    = 1'b1;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || alu_start !== 1'b0 || bus.cmd_ready !== 1'b1) quiet = 1'b0;
        end
        check("late_done ignored", 32'(quiet), 32'd1);

        // Back-to-back throughput with rsp_ready held high.
        v = '{op: 3'b001, a: 8'h01, b: 8'h02, hold: 0, en: 1'b1, exp_res: 16'h0003, exp_err: 1'b0, exp_lat: 2};
        run_cmd(v, "b2b_add0", c0);
        run_cmd(v, "b2b_add1", c1);
        check("add throughput", 32'(c1 - c0), 32'd4);
        v = '{op: 3'b100, a: 8'h0C, b: 8'h0D, hold: 0, en: 1'b1, exp_res: 16'h009C, exp_err: 1'b0, exp_lat: 5};
        run_cmd(v, "b2b_mul0", c1);
        run_cmd(v, "b2b_mul1", c2);
        check("mul throughput", 32'(c2 - c1), 32'd7);

        // Reset two cycles into a MUL drops the command without a response.
        while (bus.cmd_ready !== 1'b1) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b100;
        bus.cmd_a     = 8'h05;
        bus.cmd_b     = 8'h07;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset alu_start", 32'(alu_start), 32'd0);
        check("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || alu_start !== 1'b0) quiet = 1'b0;
        end
        check("midreset no response", 32'(quiet), 32'd1);
        v = '{op: 3'b001, a: 8'h01, b: 8'h01, hold: 0, en: 1'b1, exp_res: 16'h0002, exp_err: 1'b0, exp_lat: 2};
        run_cmd(v, "post_reset_add", c0);

        // Random commands checked against the reference model.
        for (int i = 0; i < 24; i++) begin
            v.op      = 3'($urandom_range(0, 7));
            v.a       = 8'($urandom);
            v.b       = 8'($urandom);
            v.hold    = int'($urandom_range(0, 2));
            v.en      = 1'b1;
            v.exp_res = ref_result(v.op, v.a, v.b);
            v.exp_err = 1'b0;
            v.exp_lat = ref_latency(v.op);
            run_cmd(v, $sformatf("rand%0d", i), c0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
